traffic_ctrl: RTL and testbench

TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

---
 rtl/tl_pkg.sv | 54 +++++
 rtl/traffic_ctrl_if.sv | 24 ++
 rtl/tl_down_counter.sv | 43 ++++
 rtl/traffic_ctrl.sv | 137 +++++++++++++
 tb/tb_traffic_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/tl_pkg.sv
// Shared definitions for the traffic light controller: phase codes,
// lamp encodings, countdown width and the lamp decode helper.
package tl_pkg;

  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] CNT_ZERO = 6'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 6'd1;

  // Phase codes; also driven out on the phase port.
  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_e;

  // Lamp encodings, {red,yellow,green}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
  } lights_t;

  // Lamp pattern for a phase; flash_on selects yellow vs dark in FLASH.
  function automatic lights_t decode_lights(input state_e st, input logic flash_on);
    lights_t l;
    l.ns = RED;
    l.ew = RED;
    case (st)
      NS_G:  l.ns = GRN;
      NS_Y:  l.ns = YEL;
      EW_G:  l.ew = GRN;
      EW_Y:  l.ew = YEL;
      FLASH: begin
        l.ns = flash_on ? YEL : OFF;
        l.ew = flash_on ? YEL : OFF;
      end
      default: begin
        l.ns = RED;
        l.ew = RED;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_ctrl_if.sv
// Request inputs and display/lamp outputs of the traffic light controller.
interface traffic_ctrl_if;
  import tl_pkg::*;

  logic             tick;
  logic             night;
  logic             ped_req;
  logic [2:0]       ns_light;
  logic [2:0]       ew_light;
  logic [CNT_W-1:0] count;
  logic [2:0]       phase;

  // Environment side: drives requests, observes lamps.
  modport master (
    output tick, night, ped_req,
    input  ns_light, ew_light, count, phase
  );

  // Controller side.
  modport slave (
    input  tick, night, ped_req,
    output ns_light, ew_light, count, phase
  );
endinterface

// File: rtl/tl_down_counter.sv
// Phase countdown: loadable, decrements on tick, saturates at zero.
module tl_down_counter
  import tl_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = 6'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: load has priority, then a non-wrapping decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != CNT_ZERO)) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register, asynchronously forced to the reset phase length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == CNT_ZERO);

endmodule

// File: rtl/traffic_ctrl.sv
// Two-way intersection controller with pedestrian shortening of greens
// and a night flashing-yellow mode. All parameters must lie in 1..63.
module traffic_ctrl
  import tl_pkg::*;
#(
  parameter int T_NS_GREEN = 40,
  parameter int T_EW_GREEN = 25,
  parameter int T_YELLOW   = 5,
  parameter int T_ALLRED   = 2,
  parameter int T_PED      = 5
) (
  input  logic          clk,
  input  logic          rst,
  traffic_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LD_NS  = CNT_W'(T_NS_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_EW  = CNT_W'(T_EW_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YEL = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_AR  = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_PED = CNT_W'(T_PED - 1);

  state_e           state_d, state_q;
  logic             pend_d, pend_q;
  logic             flash_d, flash_q;
  logic             ld_s;
  logic [CNT_W-1:0] ld_val_s;
  logic             dec_s;
  logic [CNT_W-1:0] cnt_s;
  logic             cnt_zero_s;
  logic             green_s;
  lights_t          lights_s;

  // Successor in the normal rotation.
  function automatic state_e next_phase(input state_e st);
    case (st)
      NS_G:    return NS_Y;
      NS_Y:    return AR1;
      AR1:     return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return AR2;
      AR2:     return NS_G;
      default: return AR2;
    endcase
  endfunction

  // Countdown value loaded on entry to a phase (its length minus one).
  function automatic logic [CNT_W-1:0] phase_load(input state_e st);
    case (st)
      NS_G:       return LD_NS;
      EW_G:       return LD_EW;
      NS_Y, EW_Y: return LD_YEL;
      AR1, AR2:   return LD_AR;
      default:    return CNT_ZERO;
    endcase
  endfunction

  tl_down_counter #(
    .RST_VAL (LD_AR)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_s),
    .load_val (ld_val_s),
    .dec      (dec_s),
    .count    (cnt_s),
    .zero     (cnt_zero_s)
  );

  assign green_s = (state_q == NS_G) || (state_q == EW_G);

  // Next state, pending flag and counter control; night beats everything.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q | bus.ped_req;
    flash_d  = flash_q;
    ld_s     = 1'b0;
    ld_val_s = CNT_ZERO;
    dec_s    = 1'b0;
    if (bus.tick) begin
      if (state_q == FLASH) begin
        if (bus.night) begin
          flash_d = ~flash_q;
        end else begin
          state_d  = AR2;
          ld_s     = 1'b1;
          ld_val_s = LD_AR;
          flash_d  = 1'b0;
          pend_d   = 1'b0;
        end
      end else if (bus.night) begin
        state_d  = FLASH;
        ld_s     = 1'b1;
        ld_val_s = CNT_ZERO;
        flash_d  = 1'b0;
        pend_d   = 1'b0;
      end else if (cnt_zero_s) begin
        state_d  = next_phase(state_q);
        ld_s     = 1'b1;
        ld_val_s = phase_load(next_phase(state_q));
        if ((next_phase(state_q) == AR1) || (next_phase(state_q) == AR2)) begin
          pend_d = 1'b0;
        end else begin
          pend_d = pend_q | bus.ped_req;
        end
      end else if (green_s && pend_d && (cnt_s > LD_PED)) begin
        ld_s     = 1'b1;
        ld_val_s = LD_PED;
        pend_d   = 1'b0;
      end else begin
        dec_s = 1'b1;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Controller registers; reset parks the junction in all-red.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= AR2;
      pend_q  <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      flash_q <= flash_d;
    end
  end

  assign lights_s     = decode_lights(state_q, flash_q);
  assign bus.ns_light = lights_s.ns;
  assign bus.ew_light = lights_s.ew;
  assign bus.count    = cnt_s;
  assign bus.phase    = state_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl: default timing, pedestrian shortening,
// night mode, asynchronous reset and a minimum-length parameter set.
module tb_traffic_ctrl;
  import tl_pkg::*;

  logic clk;
  logic rst;
  logic rst2;
  int   checks;
  int   errors;

  traffic_ctrl_if bus1 ();
  traffic_ctrl_if bus2 ();

  assign bus2.tick    = bus1.tick;
  assign bus2.night   = bus1.night;
  assign bus2.ped_req = bus1.ped_req;

  traffic_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  traffic_ctrl #(
    .T_NS_GREEN (1),
    .T_YELLOW   (1)
  ) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] ph, input int cnt,
                         input logic [2:0] ns, input logic [2:0] ew);
    chk({tag, ".phase"}, 32'(bus1.phase), 32'(ph));
    chk({tag, ".count"}, 32'(bus1.count), 32'(cnt));
    chk({tag, ".ns"},    32'(bus1.ns_light), 32'(ns));
    chk({tag, ".ew"},    32'(bus1.ew_light), 32'(ew));
  endtask

  task automatic chk2(input string tag, input logic [2:0] ph, input int cnt,
                      input logic [2:0] ns, input logic [2:0] ew);
    chk({tag, ".phase"}, 32'(bus2.phase), 32'(ph));
    chk({tag, ".count"}, 32'(bus2.count), 32'(cnt));
    chk({tag, ".ns"},    32'(bus2.ns_light), 32'(ns));
    chk({tag, ".ew"},    32'(bus2.ew_light), 32'(ew));
  endtask

  // One tick pulse, optionally with ped_req in the same clock; 4 clk total.
  task automatic do_tick(input logic ped);
    @(negedge clk);
    bus1.tick    = 1'b1;
    bus1.ped_req = ped;
    @(negedge clk);
    bus1.tick    = 1'b0;
    bus1.ped_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  task automatic ped_pulse();
    @(negedge clk);
    bus1.ped_req = 1'b1;
    @(negedge clk);
    bus1.ped_req = 1'b0;
  endtask

  // Walk a whole phase from its entry, checking the countdown each tick.
  task automatic run_phase(input string tag, input logic [2:0] ph, input int t,
                           input logic [2:0] ns, input logic [2:0] ew);
    for (int i = t - 1; i >= 0; i--) begin
      chk_all(tag, ph, i, ns, ew);
      do_tick(1'b0);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    rst2         = 1'b0;
    bus1.tick    = 1'b0;
    bus1.night   = 1'b0;
    bus1.ped_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", AR2, 1, RED, RED);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Default rotation from reset release
    run_phase("ar2_0", AR2,  2,  RED, RED);
    run_phase("nsg",   NS_G, 40, GRN, RED);
    run_phase("nsy",   NS_Y, 5,  YEL, RED);
    run_phase("ar1",   AR1,  2,  RED, RED);
    run_phase("ewg",   EW_G, 25, RED, GRN);
    run_phase("ewy",   EW_Y, 5,  RED, YEL);
    run_phase("ar2",   AR2,  2,  RED, RED);
    chk_all("nsg_again", NS_G, 39, GRN, RED);

    // Pedestrian pulse at NS_G count 30
    ticks(9);
    chk_all("ped_pre", NS_G, 30, GRN, RED);
    ped_pulse();
    repeat (2) @(negedge clk);
    chk_all("ped_hold", NS_G, 30, GRN, RED);
    do_tick(1'b0);
    chk_all("ped_short", NS_G, 4, GRN, RED);
    for (int i = 3; i >= 0; i--) begin
      do_tick(1'b0);
      chk("ped_tail.count", 32'(bus1.count), 32'(i));
    end
    do_tick(1'b0);
    chk_all("ped_nsy", NS_Y, 4, YEL, RED);

    // Pedestrian coincident with tick at EW_G count 20, then late request
    ticks(5);
    chk_all("ped_ar1", AR1, 1, RED, RED);
    ticks(2);
    chk_all("ped_ewg", EW_G, 24, RED, GRN);
    ticks(4);
    chk_all("ped_ewg20", EW_G, 20, RED, GRN);
    do_tick(1'b1);
    chk_all("ped_coinc", EW_G, 4, RED, GRN);
    do_tick(1'b0);
    chk_all("ped_ewg3", EW_G, 3, RED, GRN);
    ped_pulse();
    do_tick(1'b0);
    chk_all("ped_late", EW_G, 2, RED, GRN);
    ticks(3);
    chk_all("ped_ewy", EW_Y, 4, RED, YEL);
    ticks(5);
    chk_all("ped_ar2", AR2, 1, RED, RED);
    ticks(2);
    chk_all("ped_nsg", NS_G, 39, GRN, RED);
    do_tick(1'b0);
    chk_all("pend_cleared", NS_G, 38, GRN, RED);

    // Night mode entered from EW_G count 10
    ticks(39);
    chk_all("n_nsy", NS_Y, 4, YEL, RED);
    ticks(7);
    chk_all("n_ewg", EW_G, 24, RED, GRN);
    ticks(14);
    chk_all("n_ewg10", EW_G, 10, RED, GRN);
    bus1.night = 1'b1;
    repeat (3) @(negedge clk);
    chk_all("n_hold", EW_G, 10, RED, GRN);
    do_tick(1'b0);
    chk_all("flash_entry", FLASH, 0, OFF, OFF);
    for (int k = 1; k <= 4; k++) begin
      do_tick(1'b0);
      chk_all("flash", FLASH, 0, (k % 2 == 1) ? YEL : OFF, (k % 2 == 1) ? YEL : OFF);
    end
    bus1.night = 1'b0;
    do_tick(1'b0);
    chk_all("flash_exit", AR2, 1, RED, RED);
    do_tick(1'b0);
    chk_all("exit_ar2_0", AR2, 0, RED, RED);

    // Night beats both expiry and a coincident pedestrian request
    bus1.night = 1'b1;
    do_tick(1'b1);
    chk_all("night_prio", FLASH, 0, OFF, OFF);
    bus1.night = 1'b0;
    do_tick(1'b0);
    chk_all("prio_ar2", AR2, 1, RED, RED);
    ticks(2);
    chk_all("prio_nsg", NS_G, 39, GRN, RED);
    do_tick(1'b0);
    chk_all("prio_nopend", NS_G, 38, GRN, RED);

    // Asynchronous reset in the middle of NS_Y
    ticks(39);
    chk_all("r_nsy", NS_Y, 4, YEL, RED);
    ticks(3);
    chk_all("r_nsy1", NS_Y, 1, YEL, RED);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_all("async_rst", AR2, 1, RED, RED);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk_all("no_tick_hold", AR2, 1, RED, RED);
    ticks(2);
    chk_all("rst_nsg", NS_G, 39, GRN, RED);

    // Minimum green/yellow lengths on the second instance
    chk2("p1_reset", AR2, 1, RED, RED);
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    chk2("p1_ar2", AR2, 1, RED, RED);
    do_tick(1'b0);
    chk2("p1_ar2_0", AR2, 0, RED, RED);
    do_tick(1'b0);
    chk2("p1_nsg", NS_G, 0, GRN, RED);
    do_tick(1'b0);
    chk2("p1_nsy", NS_Y, 0, YEL, RED);
    do_tick(1'b0);
    chk2("p1_ar1", AR1, 1, RED, RED);
    ticks(2);
    chk2("p1_ewg", EW_G, 24, RED, GRN);
    ticks(25);
    chk2("p1_ewy", EW_Y, 0, RED, YEL);
    do_tick(1'b0);
    chk2("p1_ar2b", AR2, 1, RED, RED);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
